uart_tx_arb: RTL and testbench

Round-robin scheduler that shares one UART transmitter between N_REQ byte-stream requesters (e.g. CPU APB path, debug, DMA).
Each requester sends packets of bytes over a valid/ready/last interface. The arbiter locks the transmitter to one requester until the packet's last byte is sent.
It sequences the UART TX core through its start/busy handshake, one byte at a time.
It sits between requester logic and the uart core TX port, inside the uart subsystem.

---
 rtl/uart_arb_pkg.sv | 20 ++
 rtl/uart_rr_pick.sv | 29 ++
 rtl/uart_tx_arb.sv | 159 +++++++++++++++
 tb/tb_uart_tx_arb.sv | 526 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART TX round-robin arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } arb_state_t;

    localparam int N_REQ_DEF = 4;
    localparam int DW_DEF    = 8;
    localparam int TO_W_DEF  = 16;

    // Index width for a requester vector; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating priority encoder: first requester strictly after rr_ptr, wrapping.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    rr_ptr,
    output logic [IW-1:0]    pick,
    output logic             any_req
);

    // Scan rr_ptr+1 .. rr_ptr+N_REQ modulo N_REQ; the last visited slot is rr_ptr itself.
    always_comb begin
        int idx;
        idx     = 0;
        pick    = '0;
        any_req = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % N_REQ;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                pick    = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter between byte-stream requesters.
//
// state | meaning
// IDLE  | no owner; pick next requester when enabled
// GRANT | owner locked; ready offered, lock timeout counting
// START | one-cycle start pulse to the UART core
// WAIT  | UART busy; first cycle skipped (busy-rise cycle)
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int DW    = DW_DEF,
    parameter int TO_W  = TO_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [TO_W-1:0]         lock_to,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DW-1:0]     req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic [DW-1:0]           utx_data,
    output logic                    utx_start,
    input  logic                    utx_busy,
    output logic                    grant_vld,
    output logic [idx_w(N_REQ)-1:0] grant_id,
    output logic                    to_err
);

    localparam int IW = idx_w(N_REQ);

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   rr_ptr_q;
    logic [IW-1:0]   pick;
    logic            any_req;
    logic [TO_W-1:0] timer_q;
    logic [TO_W-1:0] timer_inc;
    logic            last_q;
    logic            wait_first_q;
    logic            sel_valid;
    logic            sel_last;
    logic [DW-1:0]   sel_data;
    logic            grant_new;
    logic            accept;
    logic            timeout;
    logic            pkt_done;
    logic            resume;

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req     (req_valid),
        .rr_ptr  (rr_ptr_q),
        .pick    (pick),
        .any_req (any_req)
    );

    assign sel_valid = req_valid[grant_id];
    assign sel_last  = req_last[grant_id];
    assign sel_data  = req_data[grant_id*DW +: DW];
    assign timer_inc = timer_q + 1'b1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake outputs and the events that steer the datapath.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        utx_start = 1'b0;
        grant_new = 1'b0;
        accept    = 1'b0;
        timeout   = 1'b0;
        pkt_done  = 1'b0;
        resume    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && any_req) begin
                    grant_new = 1'b1;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                req_ready[grant_id] = 1'b1;
                if (sel_valid) begin
                    accept  = 1'b1;
                    state_d = START;
                end else if (lock_to != '0 && timer_inc == lock_to) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            START: begin
                utx_start = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (!wait_first_q && !utx_busy) begin
                    if (last_q) begin
                        pkt_done = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        resume  = 1'b1;
                        state_d = GRANT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant ownership, rotation pointer, lock timer and the registered byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= IW'(N_REQ - 1);
            grant_vld    <= 1'b0;
            grant_id     <= '0;
            utx_data     <= '0;
            last_q       <= 1'b0;
            timer_q      <= '0;
            wait_first_q <= 1'b0;
            to_err       <= 1'b0;
        end else begin
            to_err       <= timeout;
            wait_first_q <= (state_q == START);
            if (grant_new) begin
                grant_id  <= pick;
                grant_vld <= 1'b1;
                timer_q   <= '0;
            end
            if (state_q == GRANT) begin
                if (accept) begin
                    utx_data <= sel_data;
                    last_q   <= sel_last;
                    timer_q  <= '0;
                end else begin
                    timer_q  <= timer_inc;
                end
            end
            if (timeout || pkt_done) begin
                grant_vld <= 1'b0;
                rr_ptr_q  <= grant_id;
                timer_q   <= '0;
            end
            if (resume) begin
                timer_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: requester queues, a UART busy model,
// an event monitor, and a packet-level round-robin reference model.
module tb_uart_tx_arb;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int TO_W = 16;

    typedef struct {
        int id;
        int data;
        int cyc;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [TO_W-1:0]   lock_to;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic [DW-1:0]     utx_data;
    logic              utx_start;
    logic              utx_busy;
    logic              grant_vld;
    logic [1:0]        grant_id;
    logic              to_err;

    int tests = 0;
    int fails = 0;

    logic [DW:0] rq [N][$];
    int          dly [N];
    int          en_off_at;
    int          stop_acc;
    int          busy_len;
    int          cyc = 0;

    ev_t sends[$];
    ev_t accepts[$];
    ev_t grants[$];
    ev_t exp_q[$];
    int  releases[$];
    int  to_errs[$];
    int  busy_falls[$];
    int  first_ready [N];
    int  ready_bad;

    uart_tx_arb #(.N_REQ(N), .DW(DW), .TO_W(TO_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .lock_to   (lock_to),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .utx_data  (utx_data),
        .utx_start (utx_start),
        .utx_busy  (utx_busy),
        .grant_vld (grant_vld),
        .grant_id  (grant_id),
        .to_err    (to_err)
    );

    always #5 clk = ~clk;

    // UART core model: busy rises the cycle after start and stays up busy_len cycles.
    initial begin
        bit st;
        int cnt;
        cnt = 0;
        utx_busy = 1'b0;
        forever begin
            @(negedge clk);
            st = (utx_start === 1'b1);
            @(posedge clk);
            #1;
            if (st) cnt = busy_len;
            else if (cnt > 0) cnt--;
            utx_busy = (cnt > 0);
        end
    end

    // Event monitor sampling on the falling edge.
    initial begin
        bit gv_p;
        bit bz_p;
        logic [N-1:0] hs;
        gv_p = 1'b0;
        bz_p = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            hs = req_valid & req_ready;
            if (utx_start === 1'b1)
                sends.push_back('{id: int'(grant_id), data: int'(utx_data), cyc: cyc});
            if (hs != '0)
                accepts.push_back('{id: int'(grant_id), data: int'(req_data[grant_id*DW +: DW]), cyc: cyc});
            if (grant_vld === 1'b1 && !gv_p)
                grants.push_back('{id: int'(grant_id), data: 0, cyc: cyc});
            if (grant_vld === 1'b0 && gv_p) releases.push_back(cyc);
            if (to_err === 1'b1) to_errs.push_back(cyc);
            if (utx_busy === 1'b0 && bz_p) busy_falls.push_back(cyc);
            for (int i = 0; i < N; i++)
                if (req_ready[i] === 1'b1 && first_ready[i] < 0) first_ready[i] = cyc;
            if (req_ready !== '0 && (grant_vld !== 1'b1 || req_ready !== (N'(1) << grant_id)))
                ready_bad++;
            gv_p = (grant_vld === 1'b1);
            bz_p = (utx_busy === 1'b1);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    task automatic clear_logs();
        sends.delete();
        accepts.delete();
        grants.delete();
        releases.delete();
        to_errs.delete();
        busy_falls.delete();
        for (int i = 0; i < N; i++) first_ready[i] = -1;
        ready_bad = 0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        en        = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        en_off_at = -1;
        stop_acc  = 0;
        for (int i = 0; i < N; i++) begin
            rq[i].delete();
            dly[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic push_byte(input int id, input int data, input bit last);
        rq[id].push_back({last, DW'(data)});
    endtask

    task automatic drive_inputs(input int k);
        logic [DW:0] e;
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0 && k >= dly[i]) begin
                e = rq[i][0];
                req_valid[i]           = 1'b1;
                req_data[i*DW +: DW]   = e[DW-1:0];
                req_last[i]            = e[DW];
            end else begin
                req_valid[i]           = 1'b0;
                req_data[i*DW +: DW]   = '0;
                req_last[i]            = 1'b0;
            end
        end
    endtask

    // mode 0: until all queues drained and arbiter quiet; 1: fixed length;
    // 2: until stop_acc bytes accepted and the UART reports busy.
    task automatic run(input int max_cyc, input int mode, output bit ok);
        logic [N-1:0] hs;
        bit           quiet;
        int           n_acc;
        n_acc = 0;
        ok = (mode == 1);
        for (int k = 0; k < max_cyc; k++) begin
            if (k == en_off_at) en = 1'b0;
            drive_inputs(k);
            @(negedge clk);
            hs = req_valid & req_ready;
            if (mode == 2 && n_acc >= stop_acc && utx_busy) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++)
                if (hs[i]) begin
                    void'(rq[i].pop_front());
                    n_acc++;
                end
            quiet = (grant_vld === 1'b0) && (utx_busy == 1'b0);
            for (int i = 0; i < N; i++) if (rq[i].size() > 0) quiet = 1'b0;
            if (mode == 0 && quiet) begin
                ok = 1'b1;
                break;
            end
        end
        if (mode != 2) begin
            drive_inputs(max_cyc);
            @(negedge clk);
            #1;
        end
    endtask

    // Reference: whole packets served in rotating order starting after requester N-1,
    // assuming every queued byte is offered as soon as it reaches the queue head.
    task automatic build_exp();
        logic [DW:0] q [N][$];
        logic [DW:0] e;
        int ptr;
        int j;
        bit found;
        for (int i = 0; i < N; i++) q[i] = rq[i];
        exp_q.delete();
        ptr = N - 1;
        forever begin
            found = 1'b0;
            for (int k = 1; k <= N && !found; k++) begin
                j = (ptr + k) % N;
                if (q[j].size() > 0) begin
                    found = 1'b1;
                    ptr = j;
                    while (q[j].size() > 0) begin
                        e = q[j].pop_front();
                        exp_q.push_back('{id: j, data: int'(e[DW-1:0]), cyc: 0});
                        if (e[DW]) break;
                    end
                end
            end
            if (!found) break;
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst       = 1'b1;
        en        = 1'b1;
        lock_to   = '0;
        req_valid = '1;
        req_data  = 32'hA5C3_5A3C;
        req_last  = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        tests++; if (req_ready !== '0) begin fails++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        tests++; if (utx_start !== 1'b0) begin fails++; $display("FAIL reset_start: got %b want 0", utx_start); end
        tests++; if (grant_vld !== 1'b0) begin fails++; $display("FAIL reset_grant_vld: got %b want 0", grant_vld); end
        tests++; if (grant_id !== 2'd0) begin fails++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        tests++; if (to_err !== 1'b0) begin fails++; $display("FAIL reset_to_err: got %b want 0", to_err); end
        tests++; if (utx_data !== 8'h00) begin fails++; $display("FAIL reset_utx_data: got %02h want 00", utx_data); end
        do_reset();
        push_byte(3, 8'h3C, 1'b1);
        push_byte(0, 8'h0C, 1'b1);
        run(200, 0, ok);
        tests++; if (!ok) begin fails++; $display("FAIL reset_first_run: got timeout want completion"); end
        tests++;
        if (grants.size() < 1 || grants[0].id != 0) begin
            fails++;
            $display("FAIL reset_first_grant: got id=%0d want id=0", (grants.size() > 0) ? grants[0].id : -1);
        end
    endtask

    task automatic test_basic();
        bit ok;
        do_reset();
        busy_len = 10;
        push_byte(1, 8'h11, 1'b0);
        push_byte(1, 8'h22, 1'b0);
        push_byte(1, 8'h33, 1'b1);
        build_exp();
        run(300, 0, ok);
        tests++; if (!ok) begin fails++; $display("FAIL basic_run: got timeout want completion"); end
        tests++; if (sends.size() != 3) begin fails++; $display("FAIL basic_count: got %0d want 3", sends.size()); end
        for (int k = 0; k < exp_q.size() && k < sends.size(); k++) begin
            tests++;
            if (sends[k].id != exp_q[k].id || sends[k].data != exp_q[k].data) begin
                fails++;
                $display("FAIL basic_send[%0d]: got id=%0d data=%02h want id=%0d data=%02h",
                         k, sends[k].id, sends[k].data, exp_q[k].id, exp_q[k].data);
            end
        end
        for (int k = 0; k < accepts.size() && k < sends.size(); k++) begin
            tests++;
            if (sends[k].cyc != accepts[k].cyc + 1) begin
                fails++;
                $display("FAIL basic_latency[%0d]: got start at %0d want %0d", k, sends[k].cyc, accepts[k].cyc + 1);
            end
        end
        tests++;
        if (grants.size() != 1 || grants[0].id != 1) begin
            fails++;
            $display("FAIL basic_grants: got count=%0d want one grant to id 1", grants.size());
        end
        if (busy_falls.size() >= 3 && releases.size() >= 1) begin
            tests++;
            if (releases[0] != busy_falls[2] + 1) begin
                fails++;
                $display("FAIL basic_release: got cycle %0d want %0d", releases[0], busy_falls[2] + 1);
            end
        end else begin
            tests++; fails++;
            $display("FAIL basic_release_seen: got falls=%0d releases=%0d want >=3 and >=1", busy_falls.size(), releases.size());
        end
        tests++; if (to_errs.size() != 0) begin fails++; $display("FAIL basic_to_err: got %0d pulses want 0", to_errs.size()); end
        tests++; if (ready_bad != 0) begin fails++; $display("FAIL basic_ready_onehot: got %0d bad cycles want 0", ready_bad); end
    endtask

    task automatic test_fairness();
        bit ok;
        do_reset();
        busy_len = 3;
        for (int p = 0; p < 4; p++) begin
            push_byte(0, 8'h40 + p, 1'b1);
            push_byte(2, 8'h60 + p, 1'b1);
        end
        build_exp();
        run(400, 0, ok);
        tests++; if (!ok) begin fails++; $display("FAIL fair_run: got timeout want completion"); end
        tests++; if (sends.size() != 8) begin fails++; $display("FAIL fair_count: got %0d want 8", sends.size()); end
        for (int k = 0; k < exp_q.size() && k < sends.size(); k++) begin
            tests++;
            if (sends[k].id != exp_q[k].id || sends[k].data != exp_q[k].data) begin
                fails++;
                $display("FAIL fair_send[%0d]: got id=%0d data=%02h want id=%0d data=%02h",
                         k, sends[k].id, sends[k].data, exp_q[k].id, exp_q[k].data);
            end
        end
        tests++;
        if (first_ready[1] != -1 || first_ready[3] != -1) begin
            fails++;
            $display("FAIL fair_idle_reqs: got ready1 at %0d ready3 at %0d want never", first_ready[1], first_ready[3]);
        end
    endtask

    task automatic test_lock();
        bit ok;
        do_reset();
        busy_len = 5;
        push_byte(1, 8'hA0, 1'b0);
        push_byte(1, 8'hA1, 1'b1);
        push_byte(0, 8'hB0, 1'b1);
        dly[0] = 5;
        run(300, 0, ok);
        tests++; if (!ok) begin fails++; $display("FAIL lock_run: got timeout want completion"); end
        tests++;
        if (sends.size() != 3 || sends[0].data != 'hA0 || sends[1].data != 'hA1 || sends[2].data != 'hB0
            || sends[1].id != 1 || sends[2].id != 0) begin
            fails++;
            $display("FAIL lock_order: got %0d sends want A0,A1 from 1 then B0 from 0", sends.size());
        end
        tests++;
        if (releases.size() < 1 || first_ready[0] != releases[0] + 1) begin
            fails++;
            $display("FAIL lock_ready0: got first ready at %0d want %0d", first_ready[0],
                     (releases.size() > 0) ? releases[0] + 1 : -1);
        end
        tests++; if (ready_bad != 0) begin fails++; $display("FAIL lock_ready_onehot: got %0d bad cycles want 0", ready_bad); end
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        busy_len = 4;
        lock_to  = 16'd5;
        push_byte(3, 8'h55, 1'b0);
        push_byte(0, 8'h0A, 1'b1);
        dly[0] = 3;
        run(300, 0, ok);
        tests++; if (!ok) begin fails++; $display("FAIL to_run: got timeout want completion"); end
        tests++; if (to_errs.size() != 1) begin fails++; $display("FAIL to_count: got %0d pulses want 1", to_errs.size()); end
        if (to_errs.size() >= 1 && busy_falls.size() >= 1 && releases.size() >= 1) begin
            tests++;
            if (to_errs[0] != busy_falls[0] + 6) begin
                fails++;
                $display("FAIL to_time: got cycle %0d want %0d", to_errs[0], busy_falls[0] + 6);
            end
            tests++;
            if (releases[0] != to_errs[0]) begin
                fails++;
                $display("FAIL to_release: got cycle %0d want %0d", releases[0], to_errs[0]);
            end
        end
        tests++;
        if (sends.size() != 2 || sends[0].id != 3 || sends[0].data != 'h55 || sends[1].id != 0 || sends[1].data != 'h0A) begin
            fails++;
            $display("FAIL to_order: got %0d sends want 55 from 3 then 0A from 0", sends.size());
        end
        lock_to = '0;
    endtask

    task automatic test_enable();
        bit ok;
        do_reset();
        busy_len = 4;
        en = 1'b0;
        for (int i = 0; i < N; i++) push_byte(i, 8'h70 + i, 1'b1);
        run(50, 1, ok);
        tests++; if (sends.size() != 0) begin fails++; $display("FAIL en_off_sends: got %0d want 0", sends.size()); end
        tests++; if (grants.size() != 0) begin fails++; $display("FAIL en_off_grants: got %0d want 0", grants.size()); end
        do_reset();
        push_byte(2, 8'hC0, 1'b0);
        push_byte(2, 8'hC1, 1'b1);
        push_byte(0, 8'hD0, 1'b1);
        dly[0]    = 3;
        en_off_at = 3;
        run(80, 1, ok);
        tests++;
        if (sends.size() != 2 || sends[0].data != 'hC0 || sends[1].data != 'hC1 || sends[1].id != 2) begin
            fails++;
            $display("FAIL en_mid_sends: got %0d sends want C0,C1 from 2", sends.size());
        end
        tests++; if (grants.size() != 1) begin fails++; $display("FAIL en_mid_grants: got %0d want 1", grants.size()); end
        tests++; if (grant_vld !== 1'b0) begin fails++; $display("FAIL en_mid_idle: got grant_vld=%b want 0", grant_vld); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        busy_len = 6;
        push_byte(1, 8'hE0, 1'b1);
        push_byte(1, 8'hE1, 1'b0);
        push_byte(1, 8'hE2, 1'b1);
        stop_acc = 2;
        run(200, 2, ok);
        tests++; if (!ok) begin fails++; $display("FAIL rmid_reach_wait: got timeout want busy"); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        tests++; if (utx_start !== 1'b0) begin fails++; $display("FAIL rmid_start: got %b want 0", utx_start); end
        tests++; if (req_ready !== '0) begin fails++; $display("FAIL rmid_ready: got %b want 0000", req_ready); end
        tests++; if (grant_vld !== 1'b0) begin fails++; $display("FAIL rmid_grant_vld: got %b want 0", grant_vld); end
        do_reset();
        push_byte(3, 8'hF3, 1'b1);
        push_byte(0, 8'hF0, 1'b1);
        build_exp();
        run(200, 0, ok);
        tests++;
        if (sends.size() != 2 || exp_q.size() != 2 || sends[0].id != exp_q[0].id || sends[1].id != exp_q[1].id) begin
            fails++;
            $display("FAIL rmid_first_after: got first id=%0d want %0d", (sends.size() > 0) ? sends[0].id : -1,
                     (exp_q.size() > 0) ? exp_q[0].id : -1);
        end
    endtask

    task automatic test_random();
        bit ok;
        int mask;
        int npk;
        int plen;
        int lat_bad;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            busy_len = $urandom_range(1, 8);
            case ($urandom_range(0, 3))
                0: lock_to = 16'd0;
                1: lock_to = 16'd1;
                2: lock_to = 16'd2;
                default: lock_to = 16'd7;
            endcase
            mask = $urandom_range(1, 15);
            for (int i = 0; i < N; i++) begin
                if (mask[i]) begin
                    npk = $urandom_range(1, 3);
                    for (int p = 0; p < npk; p++) begin
                        plen = $urandom_range(1, 3);
                        for (int b = 0; b < plen; b++)
                            push_byte(i, $urandom_range(0, 255), b == plen - 1);
                    end
                end
            end
            build_exp();
            run(3000, 0, ok);
            tests++; if (!ok) begin fails++; $display("FAIL rand%0d_run: got timeout want completion", it); end
            tests++;
            if (sends.size() != exp_q.size()) begin
                fails++;
                $display("FAIL rand%0d_count: got %0d want %0d", it, sends.size(), exp_q.size());
            end
            for (int k = 0; k < exp_q.size() && k < sends.size(); k++) begin
                tests++;
                if (sends[k].id != exp_q[k].id || sends[k].data != exp_q[k].data) begin
                    fails++;
                    $display("FAIL rand%0d_send[%0d]: got id=%0d data=%02h want id=%0d data=%02h",
                             it, k, sends[k].id, sends[k].data, exp_q[k].id, exp_q[k].data);
                end
            end
            lat_bad = 0;
            for (int k = 0; k < accepts.size() && k < sends.size(); k++)
                if (sends[k].cyc != accepts[k].cyc + 1) lat_bad++;
            tests++; if (lat_bad != 0) begin fails++; $display("FAIL rand%0d_latency: got %0d late starts want 0", it, lat_bad); end
            tests++; if (to_errs.size() != 0) begin fails++; $display("FAIL rand%0d_to_err: got %0d want 0", it, to_errs.size()); end
            tests++; if (ready_bad != 0) begin fails++; $display("FAIL rand%0d_ready: got %0d bad cycles want 0", it, ready_bad); end
        end
        lock_to = '0;
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        lock_to   = '0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        busy_len  = 10;
        en_off_at = -1;
        stop_acc  = 0;
        for (int i = 0; i < N; i++) dly[i] = 0;
        clear_logs();
        test_reset();
        test_basic();
        test_fairness();
        test_lock();
        test_timeout();
        test_enable();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
